// File: rtl/finger_pkg.sv
// Shared types and constants for the rhythm-game stages.
package finger_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned PAT_W   = 4;
  localparam int unsigned MISS_W  = 3;
  localparam int unsigned LFSR_W  = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BEAT,
    ST_ARMED,
    ST_RELEASE,
    ST_DONE
  } state_e;

  // An all-zero chord cannot be pressed, so it is replaced by a single button.
  function automatic logic [PAT_W-1:0] pattern_from_lfsr(input logic [PAT_W-1:0] nib);
    return (nib == '0) ? PAT_W'(1) : nib;
  endfunction

endpackage

// File: rtl/beat_judge_if.sv
// Player/beat inputs and judgement outputs of the beat_judge stage.
interface beat_judge_if;
  import finger_pkg::*;

  logic               start;
  logic               tick;
  logic [PAT_W-1:0]   btn;
  logic [PAT_W-1:0]   pattern;
  logic [SCORE_W-1:0] score;
  logic               C;
  logic [MISS_W-1:0]  misses;
  logic               game_over;

  modport master (
    output start, tick, btn,
    input  pattern, score, C, misses, game_over
  );

  modport slave (
    input  start, tick, btn,
    output pattern, score, C, misses, game_over
  );
endinterface

// File: rtl/beat_judge_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8
  import finger_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk) begin
    if (res) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/beat_judge.sv
// Beat pattern generator and chord judge: drives pattern/score/C to the display.
module beat_judge
  import finger_pkg::*;
#(
  parameter int unsigned       WINDOW     = 25_000_000,
  parameter int unsigned       MISS_LIMIT = 3,
  parameter logic [LFSR_W-1:0] SEED       = 8'hA5
) (
  input  logic         clk,
  input  logic         res,
  beat_judge_if.slave  bus
);

  localparam int unsigned        CNT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WINDOW - 1);
  localparam logic [MISS_W-1:0]  MISS_MAX = MISS_W'(MISS_LIMIT);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               c_q, c_d;
  logic [MISS_W-1:0]  misses_q, misses_d;
  logic               game_over_q, game_over_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_W-1:0]   btn_prev_q;

  logic [LFSR_W-1:0]  lfsr_q;
  logic               unused_lfsr_hi;
  logic               press;
  logic               hit;
  logic [MISS_W-1:0]  misses_inc;
  logic [SCORE_W-1:0] score_inc;

  lfsr8 u_lfsr (
    .clk  (clk),
    .res  (res),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:PAT_W];

  // Only a 0 -> nonzero transition counts, so a chord held into a window is ignored.
  assign press      = (bus.btn != '0) && (btn_prev_q == '0);
  assign hit        = (bus.btn == pattern_q);
  assign misses_inc = misses_q + MISS_W'(1);
  assign score_inc  = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      score_q     <= '0;
      c_q         <= 1'b0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
      cnt_q       <= '0;
      btn_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      score_q     <= score_d;
      c_q         <= c_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
      cnt_q       <= cnt_d;
      btn_prev_q  <= bus.btn;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    score_d   = score_q;
    c_d       = c_q;
    misses_d  = misses_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_WAIT_BEAT;
          pattern_d = '0;
          score_d   = '0;
          misses_d  = '0;
          c_d       = 1'b0;
        end
      end

      ST_WAIT_BEAT: begin
        if (bus.tick) begin
          pattern_d = pattern_from_lfsr(lfsr_q[PAT_W-1:0]);
          cnt_d     = CNT_LOAD;
          state_d   = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (press) begin
          pattern_d = '0;
          if (hit) begin
            score_d = score_inc;
            c_d     = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            c_d      = 1'b0;
            misses_d = misses_inc;
            state_d  = (misses_inc == MISS_MAX) ? ST_DONE : ST_RELEASE;
          end
        end else if (cnt_q == '0) begin
          pattern_d = '0;
          c_d       = 1'b0;
          misses_d  = misses_inc;
          state_d   = (misses_inc == MISS_MAX) ? ST_DONE : ST_WAIT_BEAT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (bus.btn == '0) state_d = ST_WAIT_BEAT;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign game_over_d = (state_d == ST_DONE);

  assign bus.pattern   = pattern_q;
  assign bus.score     = score_q;
  assign bus.C         = c_q;
  assign bus.misses    = misses_q;
  assign bus.game_over = game_over_q;

endmodule

// File: doc/beat_judge.md
# beat_judge

Game engine stage directly upstream of `display`: it generates the 4-bit target `pattern` on each beat and judges the player's button chord against it. It maintains the 8-bit `score` and the last-judgement flag `C`. It sits between the button debouncer / beat-tick generator and `display`, whose `score`, `pattern` and `C` inputs it drives one-to-one.

## Interface
- `WINDOW`, 25_000_000 — response window in clk cycles after a pattern appears (bench overrides to 16)
- `MISS_LIMIT`, 3 — misses before game over (1..7)
- `SEED`, 8'hA5 — LFSR reset value, must be nonzero
- `clk`  in  1  system clock
- `res`  in  1  reset, one clock, synchronous, active-high
- `start`  in  1  one-cycle pulse, begins/restarts a game
- `tick`  in  1  one-cycle beat strobe
- `btn`  in  4  debounced buttons, level, 1 = pressed
- `pattern`  out  4  target chord, 0 when no target active
- `score`  out  8  hits, saturating
- `C`  out  1  1 = last judgement was a hit
- `misses`  out  3  miss count this game
- `game_over`  out  1  high in DONE

## Operation
- States: IDLE, WAIT_BEAT, ARMED, RELEASE, DONE.
- IDLE: outputs at reset values. `start` clears `score`/`misses`/`C` and moves to WAIT_BEAT.
- WAIT_BEAT: on `tick`:
  - load `pattern` = lfsr[3:0], or 4'b0001 if lfsr[3:0]==0;
  - load window counter with WINDOW-1;
  - go to ARMED.
- ARMED: a press is the cycle where `btn`!=0 and the registered previous `btn`==0. On a press:
  - `btn`==`pattern`: hit. `score`+1, holding at 255 (never wraps to 0). `C`=1.
  - otherwise: miss. `C`=0, `misses`+1.
  - In both cases `pattern`←0 and go to RELEASE.
- ARMED with the counter at 0 and no press: miss. `pattern`←0, go to WAIT_BEAT.
- A `btn` held nonzero when entering ARMED is never judged; it must be released and pressed again.
- RELEASE: wait for `btn`==0, then go to WAIT_BEAT.
- Reaching `misses`==MISS_LIMIT goes to DONE instead of RELEASE/WAIT_BEAT.
- DONE: `game_over`=1, `pattern`=0, `score` held. `start` restarts exactly as from IDLE.
- `tick` is ignored outside WAIT_BEAT. `start` is ignored in WAIT_BEAT, ARMED and RELEASE.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. It advances every cycle, including IDLE, so patterns depend on player timing. Reset value is SEED.

## Timing
- All outputs are registered.
- Reset values: `pattern`=0, `score`=0, `C`=0, `misses`=0, `game_over`=0, state IDLE, LFSR=SEED.
- `res` overrides everything in the same edge, including mid-window.
- `tick` at cycle n in WAIT_BEAT: `pattern` is valid at n+1.
- Press at cycle n: `score`/`C`/`misses`/`pattern` update at n+1.
- Window: a press is accepted at cycles n+1 .. n+WINDOW after the tick. If none arrives, the timeout miss is visible at n+WINDOW+1.
- A press in the same cycle as the counter reaching 0: the press is judged and no timeout occurs.
- `start` and `tick` in the same cycle in IDLE/DONE: only `start` acts; that `tick` is dropped.

## Structure
- Shared package `finger_pkg` holds:
  - the state enum;
  - `SCORE_W`=8 and `PAT_W`=4;
  - `SCORE_MAX`=8'd255;
  - the LFSR tap mask 8'hB8.
- One sub-module, `lfsr8` (clk, res, seed → q[7:0]), reused by later stages.
- Window counter width is $clog2(WINDOW).

## Test plan
- Reset then `start`; `tick`; drive `btn`=`pattern` 3 cycles later → next cycle `score`=1, `C`=1, `pattern`=0.
- Armed with `pattern`=4'b0110; press `btn`=4'b0100 → `C`=0, `misses`=1, `score` unchanged.
- `tick` with `btn` held nonzero and no new press (WINDOW=16) → timeout miss visible 17 cycles after the tick. A press exactly at the 16th cycle after the tick is judged instead of timing out.
- Preload 255 hits (force or long run); one more hit → `score` stays 255, `C`=1.
- 3 misses → `game_over`=1, further `tick` leaves `pattern`=0. Then `start` → `score`=0, `misses`=0, `game_over`=0.
- Assert `res` one cycle while ARMED with `score`=5 → next cycle all outputs 0, state IDLE, the next `tick` before `start` is ignored.
